gpr_port_sequencer: RTL and testbench

Sequences all traffic on the register file's single shared access port (one select, one load strobe, combinational read data). It accepts operand-fetch requests (rs1, rs2) from decode and writeback requests (rd, data) from execute, serialises them onto the port one access per cycle, and returns both operands together with a valid/ready handshake. Sits between decode/execute and the register file, and is the only driver of the register file's GPR port.

---
 rtl/gpr_port_sequencer_if.sv | 42 ++++
 rtl/gpr_port_sequencer.sv | 125 ++++++++++++
 tb/tb_gpr_port_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/gpr_port_sequencer_if.sv
// Bundle of decode/execute handshakes and the register file GPR port.
// Latency: none, wiring only.
// Backpressure: carries the valid/ready pairs, the interface itself never stalls.
interface gpr_seq_if #(
  parameter int XLEN     = 32,
  parameter int L2_NREGS = 5
);
  logic                i_req_valid;
  logic                o_req_ready;
  logic [L2_NREGS-1:0] i_rs1;
  logic [L2_NREGS-1:0] i_rs2;
  logic                i_rs1_en;
  logic                i_rs2_en;
  logic                o_operands_valid;
  logic                i_operands_ready;
  logic [XLEN-1:0]     o_rs1_data;
  logic [XLEN-1:0]     o_rs2_data;
  logic                i_wb_valid;
  logic                o_wb_ready;
  logic [L2_NREGS-1:0] i_wb_rd;
  logic [XLEN-1:0]     i_wb_data;
  logic [L2_NREGS-1:0] o_select_gpr;
  logic                o_load_gpr;
  logic [XLEN-1:0]     o_data_to_load_gpr;
  logic [XLEN-1:0]     i_data_at_gpr;

  // Sequencer side.
  modport slave (
    input  i_req_valid, i_rs1, i_rs2, i_rs1_en, i_rs2_en, i_operands_ready,
    input  i_wb_valid, i_wb_rd, i_wb_data, i_data_at_gpr,
    output o_req_ready, o_operands_valid, o_rs1_data, o_rs2_data,
    output o_wb_ready, o_select_gpr, o_load_gpr, o_data_to_load_gpr
  );

  // Decode / execute / register file side.
  modport master (
    output i_req_valid, i_rs1, i_rs2, i_rs1_en, i_rs2_en, i_operands_ready,
    output i_wb_valid, i_wb_rd, i_wb_data, i_data_at_gpr,
    input  o_req_ready, o_operands_valid, o_rs1_data, o_rs2_data,
    input  o_wb_ready, o_select_gpr, o_load_gpr, o_data_to_load_gpr
  );
endinterface

// File: rtl/gpr_port_sequencer.sv
// Serialises operand fetches and writebacks onto the single register file GPR port.
// Latency: operands valid 2 cycles after accept (both needed), 1 cycle otherwise; writes drain 1 cycle after accept at the earliest.
// Backpressure: req_ready only in IDLE with no pending write; wb_ready while the one-entry write buffer is empty.
module gpr_port_sequencer #(
  parameter int XLEN     = 32,
  parameter int L2_NREGS = 5
) (
  input logic      i_clk,
  input logic      i_rst_n,
  gpr_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD1, RD2, DONE} state_t;

  state_t              state;
  logic [L2_NREGS-1:0] rs1_q;
  logic [L2_NREGS-1:0] rs2_q;
  logic                rs2_need_q;
  logic                valid_q;
  logic [XLEN-1:0]     rs1_data;
  logic [XLEN-1:0]     rs2_data;
  logic                wb_pend;
  logic [L2_NREGS-1:0] wb_rd;
  logic [XLEN-1:0]     wb_data;

  logic rs1_need;
  logic rs2_need;
  logic req_acc;
  logic wb_acc;
  logic wr_cycle;

  // x0 reads are free: an operand only costs a port cycle when enabled and nonzero.
  assign rs1_need = bus.i_rs1_en && (bus.i_rs1 != '0);
  assign rs2_need = bus.i_rs2_en && (bus.i_rs2 != '0);
  // A pending write must drain before a read may start.
  assign req_acc  = bus.i_req_valid && (state == IDLE) && !wb_pend;
  assign wb_acc   = bus.i_wb_valid && !wb_pend;
  // The read owns the port in RD1/RD2; writes use it only in IDLE/DONE.
  assign wr_cycle = wb_pend && ((state == IDLE) || (state == DONE));

  assign bus.o_req_ready        = (state == IDLE) && !wb_pend;
  assign bus.o_wb_ready         = !wb_pend;
  assign bus.o_operands_valid   = valid_q;
  assign bus.o_rs1_data         = rs1_data;
  assign bus.o_rs2_data         = rs2_data;
  assign bus.o_load_gpr         = wr_cycle;
  assign bus.o_data_to_load_gpr = wb_data;

  // Port select: read index during RD1/RD2, write index during a drain, else 0.
  always_comb begin
    bus.o_select_gpr = '0;
    case (state)
      RD1:     bus.o_select_gpr = rs1_q;
      RD2:     bus.o_select_gpr = rs2_q;
      default: if (wr_cycle) bus.o_select_gpr = wb_rd;
    endcase
  end

  // Read FSM with registered operand outputs and valid flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rs2_need_q <= 1'b0;
      valid_q    <= 1'b0;
      rs1_data   <= '0;
      rs2_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_acc) begin
            rs1_q      <= bus.i_rs1;
            rs2_q      <= bus.i_rs2;
            rs2_need_q <= rs2_need;
            if (!rs1_need) rs1_data <= '0;
            if (!rs2_need) rs2_data <= '0;
            if (rs1_need)      state <= RD1;
            else if (rs2_need) state <= RD2;
            else begin
              state   <= DONE;
              valid_q <= 1'b1;
            end
          end
        end
        RD1: begin
          rs1_data <= bus.i_data_at_gpr;
          if (rs2_need_q) state <= RD2;
          else begin
            state   <= DONE;
            valid_q <= 1'b1;
          end
        end
        RD2: begin
          rs2_data <= bus.i_data_at_gpr;
          state    <= DONE;
          valid_q  <= 1'b1;
        end
        DONE: begin
          if (bus.i_operands_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One-entry write buffer: fill on accept (x0 writes dropped), clear on drain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wb_pend <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else if (wr_cycle) begin
      wb_pend <= 1'b0;
    end else if (wb_acc && (bus.i_wb_rd != '0)) begin
      wb_pend <= 1'b1;
      wb_rd   <= bus.i_wb_rd;
      wb_data <= bus.i_wb_data;
    end
  end

endmodule

// File: tb/tb_gpr_port_sequencer.sv
// Directed bench for gpr_port_sequencer with a small register file on the GPR port.
// Latency: checks exact cycle of operand valid and write drain.
// Backpressure: exercises held consumer ready, write buffer full and refused writebacks.
module tb_gpr_port_sequencer;

  logic i_clk;
  logic i_rst_n;
  int   n_chk;
  int   n_bad;
  int   load_cnt;
  int   load_snap;
  logic [31:0] regs [32];

  gpr_seq_if #(.XLEN(32), .L2_NREGS(5)) bus ();

  gpr_port_sequencer #(.XLEN(32), .L2_NREGS(5)) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Register file: combinational read, write at the rising edge, x0 hardwired zero.
  assign bus.i_data_at_gpr = (bus.o_select_gpr == 5'd0) ? 32'd0 : regs[bus.o_select_gpr];
  always @(posedge i_clk) begin
    if (bus.o_load_gpr) begin
      load_cnt <= load_cnt + 1;
      if (bus.o_select_gpr != 5'd0) regs[bus.o_select_gpr] <= bus.o_data_to_load_gpr;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge i_clk);
  endtask

  task automatic req(input logic [4:0] r1, input logic e1, input logic [4:0] r2, input logic e2);
    bus.i_req_valid = 1'b1;
    bus.i_rs1 = r1; bus.i_rs1_en = e1;
    bus.i_rs2 = r2; bus.i_rs2_en = e2;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] d);
    bus.i_wb_valid = 1'b1;
    bus.i_wb_rd = rd;
    bus.i_wb_data = d;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_rdy"}, bus.o_req_ready, 1);
    check({tag, "_wb_rdy"},  bus.o_wb_ready, 1);
    check({tag, "_load"},    bus.o_load_gpr, 0);
    check({tag, "_sel"},     bus.o_select_gpr, 0);
    check({tag, "_vld"},     bus.o_operands_valid, 0);
    check({tag, "_rs1"},     bus.o_rs1_data, 0);
    check({tag, "_rs2"},     bus.o_rs2_data, 0);
  endtask

  initial begin
    n_chk = 0; n_bad = 0; load_cnt = 0;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    regs[3] = 32'h11;
    regs[7] = 32'h22;
    i_rst_n = 1'b0;
    bus.i_req_valid = 0; bus.i_rs1 = 0; bus.i_rs2 = 0; bus.i_rs1_en = 0; bus.i_rs2_en = 0;
    bus.i_operands_ready = 0; bus.i_wb_valid = 0; bus.i_wb_rd = 0; bus.i_wb_data = 0;
    repeat (3) step();
    check_reset_outputs("por");
    i_rst_n = 1'b1;
    step();
    check_reset_outputs("idle");

    // Write then read: wb x5 <= DEADBEEF, then read rs1=5, rs2=0.
    wb(5'd5, 32'hDEADBEEF);
    step();
    bus.i_wb_valid = 0;
    check("wr_load", bus.o_load_gpr, 1);
    check("wr_sel", bus.o_select_gpr, 5);
    check("wr_dat", bus.o_data_to_load_gpr, 32'hDEADBEEF);
    check("wr_req_blocked", bus.o_req_ready, 0);
    check("wr_wb_blocked", bus.o_wb_ready, 0);
    req(5'd5, 1, 5'd0, 1);
    step();
    check("wr_drained_load", bus.o_load_gpr, 0);
    check("wr_drained_req_rdy", bus.o_req_ready, 1);
    check("wr_reg5", regs[5], 32'hDEADBEEF);
    step();
    bus.i_req_valid = 0;
    check("r1_sel", bus.o_select_gpr, 5);
    check("r1_vld_early", bus.o_operands_valid, 0);
    step();
    check("r1_vld", bus.o_operands_valid, 1);
    check("r1_rs1", bus.o_rs1_data, 32'hDEADBEEF);
    check("r1_rs2", bus.o_rs2_data, 0);
    bus.i_operands_ready = 1;
    step();
    bus.i_operands_ready = 0;
    check("r1_vld_drop", bus.o_operands_valid, 0);

    // Two-operand read with consumer stalled for 4 cycles.
    req(5'd3, 1, 5'd7, 1);
    step();
    bus.i_req_valid = 0;
    check("r2_sel_rs1", bus.o_select_gpr, 3);
    step();
    check("r2_sel_rs2", bus.o_select_gpr, 7);
    check("r2_vld_early", bus.o_operands_valid, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("r2_vld_hold", bus.o_operands_valid, 1);
      check("r2_rs1_hold", bus.o_rs1_data, 32'h11);
      check("r2_rs2_hold", bus.o_rs2_data, 32'h22);
      check("r2_req_rdy_busy", bus.o_req_ready, 0);
    end
    bus.i_operands_ready = 1;
    step();
    bus.i_operands_ready = 0;
    check("r2_vld_drop", bus.o_operands_valid, 0);
    check("r2_req_rdy", bus.o_req_ready, 1);

    // Writeback to x3 arriving during RD1 of a read of x3: read sees the old value.
    req(5'd3, 1, 5'd0, 0);
    step();
    bus.i_req_valid = 0;
    check("wbr_in_rd1", bus.o_select_gpr, 3);
    check("wbr_wb_rdy", bus.o_wb_ready, 1);
    wb(5'd3, 32'h99);
    step();
    bus.i_wb_valid = 0;
    check("wbr_vld", bus.o_operands_valid, 1);
    check("wbr_rs1_old", bus.o_rs1_data, 32'h11);
    check("wbr_load_in_done", bus.o_load_gpr, 1);
    check("wbr_sel_in_done", bus.o_select_gpr, 3);
    step();
    check("wbr_drained", bus.o_load_gpr, 0);
    check("wbr_rs1_stable", bus.o_rs1_data, 32'h11);
    check("wbr_reg3", regs[3], 32'h99);
    bus.i_operands_ready = 1;
    step();
    bus.i_operands_ready = 0;
    req(5'd3, 1, 5'd0, 0);
    step();
    bus.i_req_valid = 0;
    step();
    check("wbr_reread", bus.o_rs1_data, 32'h99);
    bus.i_operands_ready = 1;
    step();
    bus.i_operands_ready = 0;

    // x0 handling: write dropped, read of x0 costs no port cycle.
    load_snap = load_cnt;
    wb(5'd0, 32'hFFFF);
    step();
    bus.i_wb_valid = 0;
    check("x0_wb_rdy", bus.o_wb_ready, 1);
    check("x0_req_rdy", bus.o_req_ready, 1);
    check("x0_load", bus.o_load_gpr, 0);
    req(5'd0, 1, 5'd9, 0);
    step();
    bus.i_req_valid = 0;
    check("x0_vld", bus.o_operands_valid, 1);
    check("x0_rs1", bus.o_rs1_data, 0);
    check("x0_rs2", bus.o_rs2_data, 0);
    check("x0_no_write", load_cnt, load_snap);
    bus.i_operands_ready = 1;
    step();
    bus.i_operands_ready = 0;

    // Backpressure: pending write blocks reads and a second writeback.
    wb(5'd9, 32'h1234);
    step();
    wb(5'd10, 32'h5678);
    check("bp_req_rdy", bus.o_req_ready, 0);
    check("bp_wb_rdy", bus.o_wb_ready, 0);
    step();
    check("bp_reg9", regs[9], 32'h1234);
    check("bp_reg10_untouched", regs[10], 0);
    check("bp_wb_rdy_back", bus.o_wb_ready, 1);
    check("bp_req_rdy_back", bus.o_req_ready, 1);
    step();
    bus.i_wb_valid = 0;
    check("bp_second_sel", bus.o_select_gpr, 10);
    check("bp_second_wb_rdy", bus.o_wb_ready, 0);
    step();
    check("bp_reg10", regs[10], 32'h5678);

    // Reset during RD2 with a write pending: everything drops, no write afterwards.
    req(5'd3, 1, 5'd7, 1);
    step();
    bus.i_req_valid = 0;
    wb(5'd12, 32'hAB);
    step();
    bus.i_wb_valid = 0;
    check("rst_in_rd2", bus.o_select_gpr, 7);
    check("rst_wb_pend", bus.o_wb_ready, 0);
    load_snap = load_cnt;
    i_rst_n = 1'b0;
    #1;
    check_reset_outputs("rst");
    repeat (2) step();
    i_rst_n = 1'b1;
    repeat (3) step();
    check("rst_no_load", load_cnt, load_snap);
    check("rst_reg12", regs[12], 0);
    check("rst_vld_after", bus.o_operands_valid, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
